mem_sched: RTL

Two-port scheduler for the 8-entry × 256-bit matrix memory. It accepts load and store requests from two requesters: port A (matrix execution unit) and port B (host/loader). It arbitrates between them round-robin and sequences the memory's enable, read/write, address and data-drive controls, one access at a time. It sits directly in front of the memory block; no requester touches the memory pins directly.

---
 rtl/mem_sched_pkg.sv | 21 ++
 rtl/mem_sched_rr_arb2.sv | 24 ++
 rtl/mem_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the two-port matrix-memory scheduler.
package mem_sched_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;

    localparam logic RW_STORE = 1'b1;
    localparam logic RW_LOAD  = 1'b0;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

endpackage

// File: rtl/mem_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that was not granted last wins.
module rr_arb2
    import mem_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lastGrant,
    output logic [1:0] grant,
    output logic       grantId
);

    always_comb begin
        grantId = PORT_A;
        if (req == 2'b11) begin
            grantId = ~lastGrant;
        end else if (req[1]) begin
            grantId = PORT_B;
        end
        grant = 2'b00;
        if (|req) begin
            grant = (grantId == PORT_B) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_sched.sv
// Round-robin load/store scheduler sequencing one access at a time into the
// 8-entry matrix memory on behalf of port A (execution unit) and port B (host).
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              reqA,
    input  logic              reqB,
    input  logic              rwA,
    input  logic              rwB,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] wdataA,
    input  logic [DATA_W-1:0] wdataB,
    output logic              ackA,
    output logic              ackB,
    output logic              errA,
    output logic              errB,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    output logic              busy,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memnEnable,
    output logic              memReadWrite,
    output logic              memDrive,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    state_t              r_state;
    state_t              w_next;
    logic                r_lastGrant;
    logic                r_grantId;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdataA;
    logic [DATA_W-1:0]   r_rdataB;

    logic [1:0]          w_grant;
    logic                w_grantId;
    logic                w_rw;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_oor;

    rr_arb2 u_arb (
        .req       ({reqB, reqA}),
        .lastGrant (r_lastGrant),
        .grant     (w_grant),
        .grantId   (w_grantId)
    );

    always_comb begin
        w_rw    = (w_grantId == PORT_B) ? rwB    : rwA;
        w_addr  = (w_grantId == PORT_B) ? addrB  : addrA;
        w_wdata = (w_grantId == PORT_B) ? wdataB : wdataA;
        // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
        w_oor   = {1'b0, w_addr} >= (ADDR_W + 1)'(DEPTH);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_next = w_oor ? ACK : ISSUE;
            ISSUE:   w_next = (r_rw == RW_STORE) ? ACK : CAPTURE;
            CAPTURE: w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_lastGrant <= PORT_B;
            r_grantId   <= PORT_A;
            r_rw        <= RW_LOAD;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_rdataA    <= '0;
            r_rdataB    <= '0;
        end else begin
            if (r_state == IDLE && |w_grant) begin
                r_grantId   <= w_grantId;
                r_lastGrant <= w_grantId;
                r_rw        <= w_rw;
                r_addr      <= w_addr;
                r_wdata     <= w_wdata;
                r_err       <= w_oor;
            end
            if (r_state == CAPTURE) begin
                if (r_grantId == PORT_B) begin
                    r_rdataB <= memRdata;
                end else begin
                    r_rdataA <= memRdata;
                end
            end
        end
    end

    always_comb begin
        busy         = (r_state != IDLE);
        ackA         = 1'b0;
        ackB         = 1'b0;
        errA         = 1'b0;
        errB         = 1'b0;
        memnEnable   = 1'b1;
        memReadWrite = RW_LOAD;
        memDrive     = 1'b0;
        memWdata     = '0;
        case (r_state)
            ISSUE: begin
                memnEnable   = 1'b0;
                memReadWrite = r_rw;
                if (r_rw == RW_STORE) begin
                    memDrive = 1'b1;
                    memWdata = r_wdata;
                end
            end
            CAPTURE: memnEnable = 1'b0;
            ACK: begin
                ackA = (r_grantId == PORT_A);
                ackB = (r_grantId == PORT_B);
                errA = (r_grantId == PORT_A) && r_err;
                errB = (r_grantId == PORT_B) && r_err;
            end
            default: ;
        endcase
    end

    assign memAddr = r_addr;
    assign rdataA  = r_rdataA;
    assign rdataB  = r_rdataB;

endmodule
